// File: rtl/byte_enabled_sdp_bram.sv
// Byte-enabled single-address block RAM: synchronous read-first read and byte-masked
// write at one shared address, mapped onto the 32-bit semi-dual-port BSRAM primitive.
module byte_enabled_sdp_bram #(
    parameter int unsigned ADDRESS_BITWIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  write_enable,
    input  logic [ADDRESS_BITWIDTH-1:0] address,
    input  logic [31:0]                 data_in,
    output logic [31:0]                 data_out
);

    localparam int unsigned DataWidth = 32;
    localparam int unsigned NumBytes  = DataWidth / 8;
    localparam int unsigned Depth     = 2 ** ADDRESS_BITWIDTH;

    // No reset on the array so the primitive is inferred; contents start at zero.
    logic [DataWidth-1:0] r_mem [Depth];
    logic [DataWidth-1:0] r_data_out;

    // The read samples the array before this edge's write lands: read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= r_mem[address];
            for (int i = 0; i < NumBytes; i++) begin
                if (write_enable[i]) begin
                    r_mem[address][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    assign data_out = r_data_out;

endmodule

// File: tb/tb_byte_enabled_sdp_bram.sv
// Self-checking bench for byte_enabled_sdp_bram: a scoreboard queue of expected read
// words, filled as each cycle is driven and drained one edge later.
module tb_byte_enabled_sdp_bram;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk;
    logic          rst;
    logic [3:0]    write_enable;
    logic [AW-1:0] address;
    logic [31:0]   data_in;
    logic [31:0]   data_out;

    int n_checks;
    int n_fail;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] model [DEPTH];

    byte_enabled_sdp_bram #(
        .ADDRESS_BITWIDTH(AW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .write_enable(write_enable),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] d);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) res[8*i +: 8] = d[8*i +: 8];
        end
        return res;
    endfunction

    // Drive one cycle, push the expected post-edge word, then pop and compare after the edge.
    task automatic step(input logic r, input logic [3:0] we, input logic [AW-1:0] a,
                        input logic [31:0] d, input string tag, input logic [31:0] exp);
        logic [31:0] e;
        string       t;
        rst          = r;
        write_enable = we;
        address      = a;
        data_in      = d;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        if (!r) model[a] = merge(model[a], we, d);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, data_out, e);
        end
    endtask

    // Random-phase cycle: expectation comes from the reference array before the write.
    task automatic step_model(input logic r, input logic [3:0] we, input logic [AW-1:0] a,
                              input logic [31:0] d);
        logic [31:0] exp;
        exp = r ? 32'h0 : model[a];
        step(r, we, a, d, "random", exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        rst          = 1'b1;
        write_enable = 4'h0;
        address      = '0;
        data_in      = 32'h0;

        step(1'b1, 4'h0, 8'd0, 32'h0, "reset_out", 32'h0);
        step(1'b1, 4'h0, 8'd0, 32'h0, "reset_out2", 32'h0);

        // Power-up contents are zero.
        step(1'b0, 4'h0, 8'd0,   32'h0, "pwrup_a0",   32'h0);
        step(1'b0, 4'h0, 8'd1,   32'h0, "pwrup_a1",   32'h0);
        step(1'b0, 4'h0, 8'd255, 32'h0, "pwrup_a255", 32'h0);

        // Full write and read-back.
        step(1'b0, 4'hF, 8'd5, 32'hDEADBEEF, "wr5_readfirst", 32'h0);
        step(1'b0, 4'h0, 8'd5, 32'h0,        "rd5_full",      32'hDEADBEEF);

        // Partial byte writes.
        step(1'b0, 4'b0101, 8'd5, 32'h11223344, "wr5_0101", 32'hDEADBEEF);
        step(1'b0, 4'b0000, 8'd5, 32'h0,        "rd5_0101", 32'hDE22BE44);
        step(1'b0, 4'b1000, 8'd5, 32'hAA000000, "wr5_1000", 32'hDE22BE44);
        step(1'b0, 4'b0000, 8'd5, 32'hFFFFFFFF, "rd5_1000", 32'hAA22BE44);

        // Read-first with address held.
        step(1'b0, 4'hF, 8'd7, 32'h12345678, "rf7_old", 32'h0);
        step(1'b0, 4'h0, 8'd7, 32'h0,        "rf7_new", 32'h12345678);

        // Reset suppresses the write and keeps contents.
        step(1'b0, 4'hF, 8'd3, 32'hCAFEF00D, "wr3",       32'h0);
        step(1'b1, 4'hF, 8'd3, 32'hFFFFFFFF, "rst_wr3",   32'h0);
        step(1'b0, 4'h0, 8'd3, 32'h0,        "rd3_after", 32'hCAFEF00D);

        // data_out holds between edges.
        @(negedge clk);
        check("hold", data_out, 32'hCAFEF00D);

        // Address extremes are independent.
        step(1'b0, 4'hF, 8'd0,   32'hA5A50001, "wr0",   32'h0);
        step(1'b0, 4'hF, 8'd255, 32'h5A5A00FF, "wr255", 32'h0);
        step(1'b0, 4'h0, 8'd0,   32'h0, "rd0",   32'hA5A50001);
        step(1'b0, 4'h0, 8'd1,   32'h0, "rd1",   32'h0);
        step(1'b0, 4'h0, 8'd254, 32'h0, "rd254", 32'h0);
        step(1'b0, 4'h0, 8'd255, 32'h0, "rd255", 32'h5A5A00FF);

        // Random traffic against the reference array, small address window to force reuse.
        for (int n = 0; n < 300; n++) begin
            logic          r;
            logic [3:0]    we;
            logic [AW-1:0] a;
            r  = ($urandom_range(0, 15) == 0);
            we = 4'($urandom_range(0, 15));
            a  = AW'($urandom_range(0, 15));
            step_model(r, we, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_enabled_sdp_bram.md
Name: byte_enabled_sdp_bram

Overview:
- Byte-enabled, single-address block RAM built on the FPGA's 32-bit BSRAM primitives.
- Each clock edge does a synchronous read and, optionally, a byte-masked write at the same address.
- Used by the cache as the tag/flags store (one instance) and as the line data columns (eight instances), all addressed by the cache line index.
- Contents power up as all zeros, so cached lines start invalid.

Parameters:
- ADDRESS_BITWIDTH, default 8: address width; depth is 2**ADDRESS_BITWIDTH words of 32 bits.

Ports:
- clk  input  1  clock; all activity on the rising edge.
- rst  input  1  reset, synchronous, active-high; clock clk.
- write_enable  input  4  byte-lane write enables; bit i enables data_in[8i+7:8i].
- address  input  ADDRESS_BITWIDTH  word address shared by read and write.
- data_in  input  32  write data.
- data_out  output  32  registered read data.

Behaviour:
- Storage is mem[0 .. 2**ADDRESS_BITWIDTH-1] of 32 bits, initialised to 0 at configuration.
- rst does not clear mem; the contents are preserved across reset.
- Write: on a rising edge with rst low, for each i with write_enable[i]=1, mem[address][8i+7:8i] <= data_in[8i+7:8i].
- Bytes whose enable bit is 0 keep their value.
- write_enable=4'b0000 means no write at all.
- Any mix of enable bits is legal, e.g. 4'b0101 writes bytes 0 and 2 only.
- Read latency is 1 cycle: on every rising edge with rst low, data_out <= mem[address].
- data_out holds its value between edges.
- Read-during-write to the same address is read-first: data_out after that edge shows the pre-write word.
- The new bytes appear on data_out one edge later, provided address is held.
- rst high at an edge:
  - data_out <= 32'h0;
  - a write requested in that cycle is suppressed;
  - mem is unchanged.
- rst asserted mid-sequence has no side effects beyond suppressing that cycle's write.
- Reset value of data_out: 32'h0000_0000.
- Address wrap: addresses are exactly ADDRESS_BITWIDTH bits; there are no out-of-range accesses.
- No handshake, no busy, no error outputs; every cycle accepts a new address.
- Must infer the vendor semi-dual-port BSRAM with byte enables:
  - no asynchronous read path;
  - no reset on the memory array;
  - register only the output.

Decomposition:
- No shared package needed; the data width (32) and byte count (4) are local constants.
- No sub-module; one always_ff block for the array write and the output register.
- The cache instantiates nine copies (one tag, eight data columns).

Test Plan:
- Power-up read: rst pulse, then read addresses 0, 1, 255 -> data_out = 0x00000000 one cycle after each address is applied.
- Full write / read-back: write 0xDEADBEEF with enable 4'b1111 at address 5, then read 5 -> data_out = 0xDEADBEEF on the next edge.
- Partial bytes: mem[5]=0xDEADBEEF, write 0x11223344 with enable 4'b0101 -> read 5 gives 0xDE22BE44. Then enable 4'b1000 with 0xAA000000 -> 0xAA22BE44.
- Read-first: hold address 7 (contains 0x0), write 0x12345678 with 4'b1111 -> data_out = 0x0 after the write edge, 0x12345678 after the following edge.
- Reset behaviour: mem[3]=0xCAFEF00D, assert rst with write_enable=4'b1111, data_in=0xFFFFFFFF, address 3 -> data_out = 0 during reset; after release, read 3 returns 0xCAFEF00D (write suppressed, contents kept).
- Address independence: write distinct patterns to addresses 0 and 2**ADDRESS_BITWIDTH-1 -> each reads back only its own value; neighbouring addresses stay 0.
